// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage definitions: address/instruction widths, reset PC,
// sequential step, HALT encoding and the fetch FSM state type.
package cpu_fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0]  RESET_PC  = 8'h00;
    localparam logic [ADDR_W-1:0]  PC_STEP   = 8'd2;
    localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

    // Instructions are halfword aligned, so redirect targets drop bit 0.
    localparam logic [ADDR_W-1:0]  PC_ALIGN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating up-counter with enable and synchronous active-low clear,
// used to count instructions captured into the IF/ID register.
module fetch_perf_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, IF/ID capture, stall/redirect handling and HALT FSM.
// Define FETCH_PERF_CNT_EN to build the captured-instruction counter on fetch_count.
module instruction_fetch_unit
    import cpu_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               if_valid,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    fetch_state_t       state_q,    state_d;
    logic [ADDR_W-1:0]  pc_q,       pc_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]  if_pc_q,    if_pc_d;
    logic               if_valid_q, if_valid_d;

    // Priority: redirect beats stall beats normal fetch; HALTED only emits bubbles.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;

        if (branch_taken) begin
            pc_d       = branch_target & PC_ALIGN_MASK;
            if_valid_d = 1'b0;
            state_d    = FETCH_RUN;
        end else if (!stall) begin
            case (state_q)
                FETCH_RUN: begin
                    if_instr_d = imem_data;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    if (imem_data == HALT_WORD) begin
                        state_d = FETCH_HALTED;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
                default: begin
                    if_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= FETCH_RUN;
            pc_q       <= RESET_PC;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_valid  = if_valid_q;
    assign halted    = (state_q == FETCH_HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic capture_en;

    // Same condition that loads if_valid with 1.
    assign capture_en = !branch_taken && !stall && (state_q == FETCH_RUN);

    fetch_perf_counter #(
        .W(16)
    ) u_perf_counter (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (capture_en),
        .count  (fetch_count)
    );
`else
    assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a cycle reference model pushes
// the expected post-edge state to a scoreboard queue, popped and compared after each edge.
module tb_instruction_fetch_unit;
    import cpu_fetch_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               stall;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic               if_valid;
    logic               halted;
    logic [15:0]        fetch_count;

    instruction_fetch_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_valid     (if_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    // Little-endian byte memory, combinational read.
    logic [7:0] mem [256];
    assign imem_data = {mem[8'(imem_addr + 8'd1)], mem[imem_addr]};

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
        logic [7:0]  ipc;
        logic        valid;
        logic        halt;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (txn %0d)", tag, obs, expv, n_txn);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {mem[8'(a + 8'd1)], mem[a]};
    endfunction

    // Drive one cycle of stimulus, predict, wait for the edge, compare.
    task automatic step(input logic rn, input logic st, input logic br, input logic [7:0] tgt);
        exp_t  e;
        logic [15:0] w;
        reset_n       = rn;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        if (!rn) begin
            m.pc = 8'h00; m.instr = 16'h0; m.ipc = 8'h00; m.valid = 1'b0; m.halt = 1'b0; m.cnt = 16'h0;
        end else if (br) begin
            m.pc = {tgt[7:1], 1'b0}; m.valid = 1'b0; m.halt = 1'b0;
        end else if (!st) begin
            if (!m.halt) begin
                w = mem_word(m.pc);
                m.instr = w; m.ipc = m.pc; m.valid = 1'b1;
                if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
                if (w == 16'h0000) m.halt = 1'b1;
                else m.pc = m.pc + 8'd2;
            end else begin
                m.valid = 1'b0;
            end
        end
        e = m;
`ifndef FETCH_PERF_CNT_EN
        e.cnt = 16'h0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_txn++;
        check_eq("imem_addr",   16'(imem_addr),   16'(e.pc));
        check_eq("if_instr",    if_instr,         e.instr);
        check_eq("if_pc",       16'(if_pc),       16'(e.ipc));
        check_eq("if_valid",    16'(if_valid),    16'(e.valid));
        check_eq("halted",      16'(halted),      16'(e.halt));
        check_eq("fetch_count", fetch_count,      e.cnt);
        $display("txn %0d rst_n=%b stall=%b br=%b tgt=%h -> addr=%h instr=%h if_pc=%h v=%b halted=%b cnt=%0d",
                 n_txn, rn, st, br, tgt, imem_addr, if_instr, if_pc, if_valid, halted, fetch_count);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
        mem[8'h00] = 8'h21; mem[8'h01] = 8'hFE;
        mem[8'h02] = 8'h22; mem[8'h03] = 8'hFB;
        mem[8'h3E] = 8'h00; mem[8'h3F] = 8'h00;
        m = '{pc: 8'h00, instr: 16'h0, ipc: 8'h00, valid: 1'b0, halt: 1'b0, cnt: 16'h0};

        // Reset
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("reset_addr", 16'(imem_addr), 16'h0000);

        // Sequential fetch of the first two words
        run(1);
        check_eq("first_instr", if_instr, 16'hFE21);
        check_eq("first_pc",    16'(if_pc), 16'h0000);
        run(1);
        check_eq("second_instr", if_instr, 16'hFB22);
        check_eq("addr_after_two", 16'(imem_addr), 16'h0004);

        // Stall for 3 cycles at pc=04, then resume
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
        check_eq("stall_hold_pc", 16'(imem_addr), 16'h0004);
        run(1);
        check_eq("resume_pc", 16'(if_pc), 16'h0004);

        // Advance to pc=10, redirect to odd target 23
        run(5);
        check_eq("pre_branch_pc", 16'(imem_addr), 16'h0010);
        step(1'b1, 1'b0, 1'b1, 8'h23);
        check_eq("branch_even", 16'(imem_addr), 16'h0022);
        check_eq("branch_flush", 16'(if_valid), 16'h0000);
        run(1);
        check_eq("branch_target_pc", 16'(if_pc), 16'h0022);
        // Branch wins over a held stall
        step(1'b1, 1'b1, 1'b1, 8'h31);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        run(1);
        check_eq("branch_over_stall", 16'(if_pc), 16'h0030);

        // HALT word at 3E
        step(1'b1, 1'b0, 1'b1, 8'h38);
        run(4);
        check_eq("halt_capture_pc", 16'(if_pc), 16'h003E);
        check_eq("halt_capture_v",  16'(if_valid), 16'h0001);
        run(3);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_eq("halt_pc_hold", 16'(imem_addr), 16'h003E);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check_eq("halt_released", 16'(halted), 16'h0000);
        run(2);

        // PC wrap at FE
        step(1'b1, 1'b0, 1'b1, 8'hFE);
        run(1);
        check_eq("wrap_addr", 16'(imem_addr), 16'h0000);
        check_eq("wrap_if_pc", 16'(if_pc), 16'h00FE);
        run(2);

        // Reset mid-stream, while halted, and during a branch
        step(1'b0, 1'b0, 1'b0, 8'h00);
        run(3);
        step(1'b1, 1'b0, 1'b1, 8'h3C);
        run(4);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        run(2);
        step(1'b0, 1'b1, 1'b1, 8'h80);
        run(2);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0),
                 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction memory.
- Holds the 8-bit byte-addressed PC and drives it as the memory address.
- Captures the returned 16-bit instruction word into an IF/ID pipeline register for decode.
- Handles decode stalls, branch redirects and HALT detection (instruction word 16'h0000).

Parameters:
- ADDR_W, 8: PC / memory address width in bits.
- INSTR_W, 16: instruction word width in bits.
- RESET_PC, 8'h00: PC value loaded on reset.
- PC_STEP, 2: byte increment per sequential fetch.
- HALT_WORD, 16'h0000: instruction encoding that halts fetch.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- imem_addr  output  ADDR_W  byte address to instruction memory; equals the pc register.
- imem_data  input  INSTR_W  instruction word from memory, combinational from imem_addr in the same cycle.
- stall  input  1  decode/hazard unit requests that the IF/ID register and PC hold.
- branch_taken  input  1  redirect request from a later stage.
- branch_target  input  ADDR_W  redirect byte address.
- if_instr  output  INSTR_W  IF/ID instruction register.
- if_pc  output  ADDR_W  address the if_instr word was fetched from.
- if_valid  output  1  if_instr holds a real instruction (0 = bubble).
- halted  output  1  FSM is in HALTED.
- fetch_count  output  16  captured-instruction count (optional feature).

Behaviour:
- Reset is synchronous: with reset_n=0 at a rising edge, pc=RESET_PC, if_instr=0, if_pc=0, if_valid=0, state=RUN, halted=0, fetch_count=0. Reset overrides everything, including mid-stall, mid-redirect and HALTED.
- imem_addr = pc (registered, no extra logic).
- FSM states: RUN and HALTED. halted is 1 exactly when state=HALTED.
- Per-edge priority: reset > branch_taken > stall > normal fetch.
- branch_taken=1, in any state, including while stall=1:
  - pc <= {branch_target[ADDR_W-1:1],1'b0} (odd targets are forced even).
  - if_valid <= 0 (flush the wrong-path word); if_instr and if_pc hold.
  - state <= RUN.
  - The target word appears in if_instr on the second edge after branch_taken is sampled.
- stall=1 and branch_taken=0: pc, if_instr, if_pc, if_valid and state all hold.
- RUN, no stall, no branch:
  - if_instr <= imem_data, if_pc <= pc, if_valid <= 1.
  - If imem_data==HALT_WORD: pc holds and state <= HALTED. The HALT word itself is delivered downstream with if_valid=1.
  - Otherwise pc <= pc+PC_STEP, modulo 2^ADDR_W (8'hFE -> 8'h00 wraps silently).
- HALTED, no stall, no branch: pc holds, if_valid <= 0, no captures. The unit stays HALTED until reset or branch_taken. A branch from an older instruction overrides a wrong-path HALT.
- Sequential throughput is one instruction per cycle; the fetch-to-if_instr latency is one edge.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: fetch_count increments by 1 on every edge where if_valid is loaded with 1, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: no counter is instantiated; the fetch_count port remains and is tied to 16'h0000.

Decomposition:
- Shared package cpu_fetch_pkg:
  - fetch_state_t enum {FETCH_RUN, FETCH_HALTED}.
  - Constants HALT_WORD, PC_STEP, RESET_PC.
  - Widths ADDR_W and INSTR_W, shared with instructionMemory and decode.
- One natural sub-module: fetch_perf_counter (saturating 16-bit counter with enable and sync reset), instantiated only under FETCH_PERF_CNT_EN. PC/FSM/IF-ID logic stays in the top.

Test Plan:
- Reset, then memory bytes [0]=21,[1]=FE,[2]=22,[3]=FB with no stall -> imem_addr 00,02,04 on successive cycles; if_instr=16'hFE21 with if_pc=00, then 16'hFB22 with if_pc=02; if_valid=1 from the first capture edge.
- stall=1 for 3 cycles at pc=04 -> pc, if_instr, if_pc and if_valid unchanged for all 3 cycles; normal fetch resumes from 04 with no word lost or duplicated.
- branch_taken=1 with branch_target=8'h23 while pc=10 -> next cycle pc=8'h22 and if_valid=0; the following edge gives if_pc=8'h22 and if_valid=1. Repeat with stall=1 held -> the branch still wins.
- Word 16'h0000 at 8'h3E -> captured with if_valid=1 and if_pc=3E; halted=1 next; if_valid=0 thereafter; pc stays 3E. Then branch_taken to 8'h00 -> halted=0 and fetch restarts at 00.
- pc=8'hFE with a non-HALT word -> pc wraps to 8'h00; if_pc=8'hFE.
- reset_n=0 for one edge mid-stream, while HALTED and during a branch -> all outputs at reset values on that edge; fetch_count (FETCH_PERF_CNT_EN) equals the number of valid captures and stays 0 when the macro is undefined.
